// File: rtl/bt_cmd_pkg.sv
// Shared definitions for the Bluetooth command-frame controller:
// FSM state encoding, default sync marker and game opcodes.
package bt_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [7:0] CMD_MOVE  = 8'h01;
  localparam logic [7:0] CMD_FIRE  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;
  localparam logic [7:0] CMD_PAUSE = 8'h04;

endpackage

// File: rtl/bt_cmd_timeout.sv
// Inter-byte timeout counter: clear beats load beats count; tc flags TERM-1
// and counting stops there until the owner clears it.
module bt_cmd_timeout #(
  parameter int unsigned TERM = 50,
  parameter int unsigned W    = $clog2(TERM + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  // Counter state: cleared on demand, otherwise loaded or advanced.
  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (ld)          cnt <= ld_val;
    else if (en && !tc)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/bt_cmd_ctrl.sv
// Command-frame controller behind the UART receiver.
// Frame: SYNC, CMD, LEN, LEN payload bytes, optional XOR checksum.
// Define BT_CMD_CHECKSUM_EN to require the trailing checksum byte; without
// it the last payload byte (or a zero LEN) completes the frame.
module bt_cmd_ctrl
  import bt_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned TIMEOUT_MS = 10,
  parameter int unsigned MAX_LEN    = 4,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  output logic [7:0]           o_cmd,
  output logic [MAX_LEN*8-1:0] o_arg,
  output logic [2:0]           o_len,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ready,
  output logic                 o_busy,
  output logic [7:0]           o_err_cnt
);

  localparam int unsigned TIMEOUT_CLKS = (CLK_FREQ / 1000) * TIMEOUT_MS;
  localparam int unsigned TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]  MAX_LEN_B    = 8'(MAX_LEN);

`ifdef BT_CMD_CHECKSUM_EN
  localparam state_t ST_LAST = S_CSUM;
`else
  localparam state_t ST_LAST = S_HOLD;
`endif

  state_t                    state;
  logic                      done_q;
  logic                      rx_stb;
  logic [7:0]                cmd_q;
  logic [2:0]                len_q;
  logic [2:0]                idx;
  logic                      valid_q;
  logic [MAX_LEN-1:0][7:0]   payload;
  logic [7:0]                err_cnt;
  logic                      active;
  logic                      to_tc;
  logic                      to_fire;
  logic                      err_ev;
  logic                      pay_clr;
  logic                      pay_wr;
`ifdef BT_CMD_CHECKSUM_EN
  logic [7:0]                csum;
`endif

  assign o_cmd       = cmd_q;
  assign o_arg       = payload;
  assign o_len       = len_q;
  assign o_cmd_valid = valid_q;
  assign o_busy      = (state != S_IDLE);
  assign o_err_cnt   = err_cnt;

  // Strobe decode, timeout firing and error-event detection.
  always_comb begin
    rx_stb  = i_rx_done & ~done_q;
    active  = (state == S_CMD) || (state == S_LEN) ||
              (state == S_PAYLOAD) || (state == S_CSUM);
    to_fire = active & ~rx_stb & to_tc;
    pay_clr = rx_stb && (state == S_IDLE) && (i_rx_data == SYNC_BYTE);
    pay_wr  = rx_stb && (state == S_PAYLOAD);
    err_ev  = to_fire;
    if (rx_stb) begin
      case (state)
        S_LEN:  if (i_rx_data > MAX_LEN_B) err_ev = 1'b1;
`ifdef BT_CMD_CHECKSUM_EN
        S_CSUM: if (i_rx_data != csum)     err_ev = 1'b1;
`endif
        S_HOLD: err_ev = 1'b1;
        default: ;
      endcase
    end
  end

  // Edge detect on the receiver done flag so a held done is one byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) done_q <= 1'b0;
    else          done_q <= i_rx_done;
  end

  bt_cmd_timeout #(
    .TERM (TIMEOUT_CLKS),
    .W    (TW)
  ) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (rx_stb | ~active | to_fire),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (active),
    .tc     (to_tc)
  );

  // Frame sequencer; a byte arriving in the timeout cycle wins over the timeout.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
`ifdef BT_CMD_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_stb && i_rx_data == SYNC_BYTE) state <= S_CMD;
        end
        S_CMD: begin
          if (rx_stb) begin
            cmd_q <= i_rx_data;
`ifdef BT_CMD_CHECKSUM_EN
            csum  <= i_rx_data;
`endif
            state <= S_LEN;
          end else if (to_tc) state <= S_IDLE;
        end
        S_LEN: begin
          if (rx_stb) begin
`ifdef BT_CMD_CHECKSUM_EN
            csum <= csum ^ i_rx_data;
`endif
            if (i_rx_data > MAX_LEN_B) begin
              state <= S_IDLE;
            end else begin
              len_q <= i_rx_data[2:0];
              idx   <= '0;
              if (i_rx_data == 8'd0) begin
                state <= ST_LAST;
                if (ST_LAST == S_HOLD) valid_q <= 1'b1;
              end else begin
                state <= S_PAYLOAD;
              end
            end
          end else if (to_tc) state <= S_IDLE;
        end
        S_PAYLOAD: begin
          if (rx_stb) begin
`ifdef BT_CMD_CHECKSUM_EN
            csum <= csum ^ i_rx_data;
`endif
            idx <= idx + 3'd1;
            if (idx + 3'd1 == len_q) begin
              state <= ST_LAST;
              if (ST_LAST == S_HOLD) valid_q <= 1'b1;
            end
          end else if (to_tc) state <= S_IDLE;
        end
`ifdef BT_CMD_CHECKSUM_EN
        S_CSUM: begin
          if (rx_stb) begin
            if (i_rx_data == csum) begin
              state   <= S_HOLD;
              valid_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (to_tc) state <= S_IDLE;
        end
`endif
        S_HOLD: begin
          // Overrun bytes are dropped (counted via err_ev); the held frame stays.
          if (i_cmd_ready) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload store: cleared when a new frame starts so unused bytes read zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || pay_clr) begin
      payload <= '0;
    end else if (pay_wr) begin
      for (int k = 0; k < MAX_LEN; k++)
        if (idx == 3'(k)) payload[k] <= i_rx_data;
    end
  end

  // Dropped-frame counter, saturating at 255.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                        err_cnt <= '0;
    else if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: doc/bt_cmd_ctrl.md
Name: bt_cmd_ctrl

Overview:
- Frame controller sitting directly behind the UART receiver in bt_control.
- Consumes received bytes and their done strobe, then sequences them through a command-frame state machine: sync, command, length, payload, checksum.
- Delivers validated commands to game logic over a valid/ready handshake.
- Drops malformed, oversized, stalled or overrun frames and counts them.

Parameters:
- CLK_FREQ, 12000000: system clock frequency in Hz.
- TIMEOUT_MS, 10: inter-byte timeout in milliseconds; TIMEOUT_CLKS = (CLK_FREQ/1000)*TIMEOUT_MS.
- MAX_LEN, 4: maximum payload bytes, range 1..7.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_rx_data  in  8  byte from UART receiver; valid while i_rx_done is high.
- i_rx_done  in  1  receiver byte-complete; may be held for more than one cycle.
- o_cmd  out  8  command byte of the delivered frame.
- o_arg  out  MAX_LEN*8  payload; byte k at bits [8k+7:8k]; unused bytes zero.
- o_len  out  3  payload length of the delivered frame.
- o_cmd_valid  out  1  frame available.
- i_cmd_ready  in  1  consumer accepts frame.
- o_busy  out  1  high in any state other than IDLE.
- o_err_cnt  out  8  saturating count of dropped frames/bytes.

Behaviour:
- Reset (i_rst_n=0 at a clock edge), all outputs and state:
  - o_cmd=0, o_arg=0, o_len=0, o_cmd_valid=0, o_busy=0, o_err_cnt=0.
  - State IDLE; timeout counter 0; edge-detect register 0.
  - Reset mid-frame or mid-HOLD discards the frame and does not count an error.
- Byte strobe: rx_stb = i_rx_done & ~done_q, where done_q is i_rx_done registered. A held done yields exactly one byte.
- States and transitions, all evaluated on rx_stb:
  - IDLE: byte==SYNC_BYTE -> CMD. Any other byte is silently dropped, no error.
  - CMD: latch byte into cmd register, start checksum = byte -> LEN.
  - LEN: byte>MAX_LEN -> error, IDLE. byte==0 -> CSUM. Otherwise -> PAYLOAD. Checksum ^= byte in all cases.
  - PAYLOAD: store byte at index idx, checksum ^= byte, idx++. When idx reaches len -> CSUM.
  - CSUM: byte==checksum -> HOLD with o_cmd_valid=1 the next cycle. Mismatch -> error, IDLE.
  - HOLD: o_cmd/o_arg/o_len stable and o_cmd_valid=1 until i_cmd_ready=1.
    - Handshake cycle: o_cmd_valid deasserts next cycle, state -> IDLE.
    - rx_stb during HOLD: byte dropped, error counted, remain in HOLD. Overrun policy: the held frame wins.
    - rx_stb in the same cycle as handshake: byte still dropped and counted.
- Latency: o_cmd_valid rises 1 cycle after the rx_stb of the final frame byte.
- Timeout:
  - Counter clears on every rx_stb and in IDLE/HOLD.
  - Increments in CMD, LEN, PAYLOAD, CSUM.
  - Reaching TIMEOUT_CLKS-1 -> error, IDLE; counter clears.
  - rx_stb in the timeout cycle takes priority: byte processed, no timeout.
- Error counter: +1 per error event, saturates at 255, never wraps. Cleared only by reset.
- Payload register clears on entry to CMD, so bytes beyond len read zero.
- Widths: idx and len are 3 bits; checksum is 8-bit XOR.

Optional Feature:
- Macro BT_CMD_CHECKSUM_EN.
- Defined: checksum byte present and checked as above.
- Undefined: frame carries no checksum byte. CSUM state and checksum register are absent. Last payload byte (or LEN==0) goes directly to HOLD. Latency is unchanged relative to the final byte.

Decomposition:
- Package bt_cmd_pkg:
  - State encoding localparams IDLE/CMD/LEN/PAYLOAD/CSUM/HOLD.
  - SYNC_BYTE default.
  - Command opcode constants: CMD_MOVE=8'h01, CMD_FIRE=8'h02, CMD_START=8'h03, CMD_PAUSE=8'h04.
- One natural sub-module: bt_cmd_timeout. Loadable counter with clear, enable and terminal-count output, reused for the inter-byte timeout.

Test Plan:
- Good frame A5 01 02 10 20 cks=01^02^10^20=0x33, i_cmd_ready=1 -> o_cmd_valid one cycle after the last byte; o_cmd=01, o_len=2, o_arg=32'h00002010; o_err_cnt=0.
- Bad checksum A5 02 00 FF -> no o_cmd_valid, o_err_cnt=1, o_busy=0. Next frame A5 02 00 02 -> delivered with o_cmd=02, o_len=0.
- Length violation A5 01 05 (MAX_LEN=4) -> error count +1, IDLE. Junk bytes 00 FF 5A before a sync -> ignored, count unchanged.
- Backpressure: hold i_cmd_ready=0 for 100 cycles after a good frame, inject byte 0x11 -> o_cmd_valid stays 1, outputs stable, o_err_cnt +1; assert ready -> valid drops next cycle.
- Timeout, TIMEOUT_CLKS overridden to 50: send A5 01 and stall -> IDLE after 50 cycles, error +1. Also hold i_rx_done high 20 cycles -> only one byte consumed.
- Reset mid-PAYLOAD, then 300 forced error events -> state IDLE, counter 0 after reset; counter saturates at 255.
